// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
package seq_det_pkg;

    localparam int unsigned PAT_W_MIN   = 2;
    localparam int unsigned PAT_W_MAX   = 32;
    localparam logic [3:0]  PAT_DEFAULT = 4'b1101;

    typedef enum logic {
        MODE_NOVL = 1'b0,
        MODE_OVL  = 1'b1
    } ovl_mode_e;

    // Fill counter must represent 0..pat_w inclusive.
    function automatic int unsigned fill_width(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_param_if.sv
// Serial stream, pattern-load and counter signals of the sequence detector.
interface seq_det_param_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    logic             x;
    logic             x_vld;
    logic             ovl;
    logic             pat_ld;
    logic [PAT_W-1:0] pat_in;
    logic             y;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt;

    modport master (
        output x, x_vld, ovl, pat_ld, pat_in, cnt_clr,
        input  y, cnt
    );

    modport slave (
        input  x, x_vld, ovl, pat_ld, pat_in, cnt_clr,
        output y, cnt
    );
endinterface

// File: rtl/seq_det_hist.sv
// History shift register and fill counter; flags a match on the upcoming edge.
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x_i,
    input  logic             x_vld_i,
    input  logic             ovl_i,
    input  logic             pat_ld_i,
    input  logic [PAT_W-1:0] pat_i,
    output logic             match_o
);
    localparam int unsigned FILL_W = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;

    always_comb begin
        hist_d   = hist_q;
        fill_d   = fill_q;
        match_o  = 1'b0;
        fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        if (pat_ld_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (x_vld_i) begin
            hist_d = {hist_q[PAT_W-2:0], x_i};
            fill_d = fill_inc;
            // Fill gating keeps reset zeros from completing a partial pattern.
            if ((hist_d == pat_i) && (fill_inc == FILL_FULL)) begin
                match_o = 1'b1;
                if (ovl_mode_e'(ovl_i) == MODE_NOVL) begin
                    fill_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_param.sv
// Moore detector for a runtime-loadable pattern; SEQ_DET_CNT_EN adds a
// saturating match counter.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_DEFAULT),
    parameter int unsigned      CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_det_param_if.slave bus
);
    logic [PAT_W-1:0] pat_q;
    logic             y_q;
    logic             match;

    seq_det_hist #(
        .PAT_W (PAT_W)
    ) u_hist (
        .clk      (clk),
        .rst_n    (rst_n),
        .x_i      (bus.x),
        .x_vld_i  (bus.x_vld),
        .ovl_i    (bus.ovl),
        .pat_ld_i (bus.pat_ld),
        .pat_i    (pat_q),
        .match_o  (match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= PAT_RST;
            y_q   <= 1'b0;
        end else begin
            if (bus.pat_ld) begin
                pat_q <= bus.pat_in;
            end
            y_q <= match;
        end
    end

    assign bus.y = y_q;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.cnt = cnt_q;
`else
    logic cnt_clr_unused;
    assign cnt_clr_unused = bus.cnt_clr;
    assign bus.cnt        = '0;
`endif

endmodule
